// File: rtl/mips_pkg.sv
// Shared pipeline definitions: data-memory bridge state encoding and bus constants.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int         TIMEOUT_CYCLES_DEF = 255;
    localparam logic [3:0] BE_ALL             = 4'b1111;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Saturating wait-cycle counter for the data-memory bridge (used when DMEM_TIMEOUT_EN is defined).
module dmem_timeout_ctr #(
    parameter int LIMIT = 255,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CW'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the LIMIT-th consecutive enabled cycle.
    assign expire = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// M-stage data-memory bridge: registered request/ready bus transaction with stall-friendly ack.
// Optional REQ timeout abort is compiled in when DMEM_TIMEOUT_EN is defined.
module dmem_bridge
    import mips_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_M,
    input  logic              mem_write_M,
    input  logic [31:0]       alu_out_M,
    input  logic [31:0]       write_data_M,
    input  logic [3:0]        byte_en_M,
    input  logic              flush_M,
    input  logic              m_advance,
    output logic [31:0]       read_data_M,
    output logic              data_mem_ack,
    output logic              mem_err_M,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_err
);

    dmem_state_t state, state_nx;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        flush_seen;
    logic        tmo_expire;
    logic        access;
    logic [31:0] word_addr;

    assign access    = mem_read_M | mem_write_M;
    assign word_addr = {alu_out_M[31:2], 2'b00};

`ifdef DMEM_TIMEOUT_EN
    dmem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (state != REQ),
        .en     ((state == REQ) && !bus_ready),
        .expire (tmo_expire)
    );
`else
    // No timer: REQ waits for the slave forever (the parameter only matters with the timer).
    assign tmo_expire = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_nx     = state;
        data_mem_ack = 1'b1;
        case (state)
            IDLE: begin
                data_mem_ack = ~access | flush_M;
                if (access && !flush_M) state_nx = REQ;
            end
            REQ: begin
                data_mem_ack = 1'b0;
                // A flush seen at any point in REQ discards the result instead of presenting it.
                if (bus_ready || tmo_expire)
                    state_nx = (flush_seen || flush_M) ? IDLE : DONE;
            end
            DONE: begin
                if (m_advance || flush_M) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign read_data_M = (state == DONE) ? rdata_q : 32'd0;
    assign mem_err_M   = (state == DONE) ? err_q   : 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            flush_seen <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (access && !flush_M) begin
                        // A simultaneous read+write is issued as a write.
                        bus_req    <= 1'b1;
                        bus_we     <= mem_write_M;
                        bus_addr   <= ADDR_W'(word_addr);
                        bus_wdata  <= mem_write_M ? write_data_M : 32'd0;
                        bus_be     <= mem_write_M ? byte_en_M : BE_ALL;
                        flush_seen <= 1'b0;
                    end
                end
                REQ: begin
                    if (flush_M) flush_seen <= 1'b1;
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        rdata_q <= bus_we ? 32'd0 : bus_rdata;
                        err_q   <= bus_err;
                    end else if (tmo_expire) begin
                        bus_req <= 1'b0;
                        rdata_q <= 32'd0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed cases plus randomized accesses against a word-memory slave model.
module tb_dmem_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_M, mem_write_M, flush_M, m_advance;
    logic [31:0] alu_out_M, write_data_M;
    logic [3:0]  byte_en_M;
    logic [31:0] read_data_M;
    logic        data_mem_ack, mem_err_M;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready, bus_err;
    logic [31:0] bus_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [16];

    always #5 clk = ~clk;

    dmem_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read_M   (mem_read_M),
        .mem_write_M  (mem_write_M),
        .alu_out_M    (alu_out_M),
        .write_data_M (write_data_M),
        .byte_en_M    (byte_en_M),
        .flush_M      (flush_M),
        .m_advance    (m_advance),
        .read_data_M  (read_data_M),
        .data_mem_ack (data_mem_ack),
        .mem_err_M    (mem_err_M),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata),
        .bus_err      (bus_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access: IDLE request cycle, waits+1 REQ cycles, DONE held for stall+1 cycles.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] be,
                             input int waits, input bit err, input int stall);
        logic [31:0] exp_addr, exp_rd;
        logic [3:0]  exp_be;
        int          idx;
        exp_addr = {addr[31:2], 2'b00};
        exp_be   = wr ? be : 4'hF;
        idx      = int'(addr[5:2]);

        @(posedge clk); #1;
        mem_read_M = rd; mem_write_M = wr; alu_out_M = addr;
        write_data_M = wd; byte_en_M = be; m_advance = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        check_eq("idle_ack_low", data_mem_ack, 0);
        check_eq("idle_no_req", bus_req, 0);

        for (int w = 0; w <= waits; w++) begin
            @(posedge clk); #1;
            bus_ready = (w == waits);
            bus_rdata = bus_ready ? mem[idx] : $urandom;
            bus_err   = bus_ready ? err : 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("req_valid", bus_req, 1);
            check_eq("req_addr", bus_addr, exp_addr);
            check_eq("req_we", bus_we, wr);
            check_eq("req_be", bus_be, exp_be);
            check_eq("req_ack_low", data_mem_ack, 0);
            if (wr) check_eq("req_wdata", bus_wdata, wd);
        end

        exp_rd = wr ? 32'd0 : mem[idx];
        if (wr && !err)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];

        @(posedge clk); #1;
        bus_ready = 1'b0; bus_rdata = $urandom; bus_err = 1'($urandom_range(0, 1));
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            check_eq("done_ack", data_mem_ack, 1);
            check_eq("done_rdata", read_data_M, exp_rd);
            check_eq("done_err", mem_err_M, err);
            check_eq("done_no_req", bus_req, 0);
            if (s < stall) begin
                @(posedge clk); #1;
            end
        end
        m_advance = 1'b1;
        @(posedge clk); #1;
        mem_read_M = 1'b0; mem_write_M = 1'b0; m_advance = 1'b0;
        @(negedge clk);
        check_eq("post_ack", data_mem_ack, 1);
        check_eq("post_no_req", bus_req, 0);
        check_eq("post_rdata", read_data_M, 0);
    endtask

    // Read that gets flushed in REQ cycle flush_at; the result must never surface.
    task automatic do_flush(input logic [31:0] addr, input int waits, input int flush_at);
        @(posedge clk); #1;
        mem_read_M = 1'b1; alu_out_M = addr; m_advance = 1'b0;
        for (int w = 0; w <= waits; w++) begin
            @(posedge clk); #1;
            bus_ready = (w == waits);
            bus_rdata = $urandom | 32'h1;
            bus_err   = bus_ready;
            flush_M   = (w == flush_at);
            if (w == flush_at) mem_read_M = 1'b0;
            @(negedge clk);
            check_eq("flush_req_held", bus_req, 1);
            check_eq("flush_ack_low", data_mem_ack, 0);
        end
        @(posedge clk); #1;
        bus_ready = 1'b0; flush_M = 1'b0; bus_err = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("flush_ack_idle", data_mem_ack, 1);
            check_eq("flush_no_data", read_data_M, 0);
            check_eq("flush_no_err", mem_err_M, 0);
            check_eq("flush_no_reissue", bus_req, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        mem_read_M = 0; mem_write_M = 0; flush_M = 0; m_advance = 0;
        alu_out_M = 0; write_data_M = 0; byte_en_M = 0;
        bus_ready = 0; bus_rdata = 0; bus_err = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", bus_req, 0);
        check_eq("rst_we", bus_we, 0);
        check_eq("rst_addr", bus_addr, 0);
        check_eq("rst_wdata", bus_wdata, 0);
        check_eq("rst_be", bus_be, 0);
        check_eq("rst_ack", data_mem_ack, 1);
        check_eq("rst_rdata", read_data_M, 0);
        check_eq("rst_err", mem_err_M, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Zero-wait load with sub-word address.
        mem[1] = 32'hCAFE_F00D;
        do_access(1, 0, 32'h0000_1006, 32'h0, 4'h0, 0, 0, 0);
        // Store with three wait states.
        do_access(0, 1, 32'h0000_2008, 32'h5A5A_5A5A, 4'b0100, 3, 0, 0);
        // Load held in DONE by an M-stage stall.
        do_access(1, 0, 32'h0000_2008, 32'h0, 4'h0, 1, 0, 5);
        // Slave error on a completed read.
        do_access(1, 0, 32'h0000_0030, 32'h0, 4'h0, 0, 1, 0);
        // Read and write together behave as a write.
        do_access(1, 1, 32'h0000_0014, 32'h1234_5678, 4'b1001, 1, 0, 1);

        do_flush(32'h0000_0040, 3, 1);
        do_flush(32'h0000_0044, 2, 2);

        // Asynchronous reset while the transaction is outstanding.
        @(posedge clk); #1;
        mem_read_M = 1'b1; alu_out_M = 32'h0000_0108;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        @(negedge clk);
        check_eq("arst_pre_req", bus_req, 1);
        #1 reset = 1'b0;
        #1;
        check_eq("arst_req_drop", bus_req, 0);
        check_eq("arst_ack_idle", data_mem_ack, 0);
        check_eq("arst_addr", bus_addr, 0);
        check_eq("arst_rdata", read_data_M, 0);
        @(posedge clk); #1;
        mem_read_M = 1'b0; reset = 1'b1;
        @(negedge clk);
        check_eq("arst_ack_free", data_mem_ack, 1);

`ifdef DMEM_TIMEOUT_EN
        @(posedge clk); #1;
        mem_read_M = 1'b1; alu_out_M = 32'h0000_0200; bus_ready = 1'b0;
        bus_rdata = 32'hDEAD_BEEF; bus_err = 1'b0;
        for (int w = 0; w < TMO; w++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("tmo_req_held", bus_req, 1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("tmo_req_drop", bus_req, 0);
        check_eq("tmo_ack", data_mem_ack, 1);
        check_eq("tmo_err", mem_err_M, 1);
        check_eq("tmo_rdata", read_data_M, 0);
        m_advance = 1'b1;
        @(posedge clk); #1;
        mem_read_M = 1'b0; m_advance = 1'b0;
`endif

        // Randomized accesses against the slave memory model.
        for (int n = 0; n < 24; n++) begin
            bit          rd, wr;
            logic [31:0] addr;
            int          kind;
            kind = $urandom_range(0, 2);
            rd   = (kind != 1);
            wr   = (kind != 0);
            addr = {$urandom_range(0, 255), $urandom_range(0, 15), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_access(rd, wr, addr, $urandom, 4'($urandom_range(1, 15)),
                      $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Memory-stage data-memory interface between the M-stage datapath outputs and an external single-port data bus.
- Consumes the M-stage address, store data and byte enables; runs a registered request/ready transaction on the bus.
- Returns read_data_M and data_mem_ack, which feed the M-stage load path and the hazard unit.
- Holds ack low while a transaction is outstanding, so the pipeline stalls across bus wait states.

Parameters:
- ADDR_W, 32, bus address width; bits [1:0] are forced to 0 on the bus.
- TIMEOUT_CYCLES, 255, number of wait cycles in REQ before abort (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- mem_read_M  in  1  M-stage load
- mem_write_M  in  1  M-stage store
- alu_out_M  in  32  byte address
- write_data_M  in  32  replicated store data
- byte_en_M  in  4  store byte lanes
- flush_M  in  1  M-stage flush
- m_advance  in  1  M→W register enable (~stall_W) this cycle
- read_data_M  out  32  load data to the M-stage load path
- data_mem_ack  out  1  1 = no access pending or access complete
- mem_err_M  out  1  bus error/timeout on completed access
- bus_req  out  1  transaction valid
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word address
- bus_wdata  out  32  write data
- bus_be  out  4  byte enables (4'b1111 for reads)
- bus_ready  in  1  slave completes transaction this cycle
- bus_rdata  in  32  read data, valid with bus_ready
- bus_err  in  1  slave error, valid with bus_ready

Behaviour:
- FSM states: IDLE, REQ, DONE. All outputs are registered or state-decoded; there is no combinational path from bus_ready to data_mem_ack.
- Reset (reset=0, asynchronous):
  - state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0.
  - rdata_q=0, err_q=0, timer=0.
- Outputs by state:
  - IDLE: data_mem_ack = ~(mem_read_M | mem_write_M) | flush_M.
  - REQ: data_mem_ack=0.
  - DONE: data_mem_ack=1.
  - read_data_M = rdata_q in DONE, else 0.
  - mem_err_M = err_q in DONE, else 0.
- IDLE, access requested and flush_M=0:
  - Latch the bus fields; enter REQ.
  - Both read and write set: treat as a write.
- REQ:
  - bus_req=1; address, data, byte enables and direction held stable.
  - On bus_ready=1: capture bus_rdata (reads) or 0 (writes) into rdata_q and bus_err into err_q; drop bus_req; enter DONE.
- DONE:
  - Hold until m_advance=1, then return to IDLE.
  - No re-issue of the same access while M is stalled for other reasons.
- Latency: request seen in cycle 0 → bus_req in cycle 1 → if ready in cycle 1, ack=1 and data valid in cycle 2. Each bus wait cycle adds 1.
- flush_M:
  - IDLE: request ignored.
  - REQ: the bus transaction is not aborted. It completes, then the FSM goes directly to IDLE (result discarded, no DONE).
  - DONE: go to IDLE.
- Reset mid-transaction: bus_req drops immediately; the slave must tolerate abandonment.
- Back-to-back accesses: DONE→IDLE costs one cycle; the next request issues from IDLE.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- When defined:
  - timer counts REQ cycles with bus_ready=0.
  - At TIMEOUT_CYCLES: drop bus_req, rdata_q=0, err_q=1, enter DONE.
  - timer clears on entering REQ.
- When undefined:
  - REQ waits indefinitely; timer logic is absent.
  - err_q reflects only bus_err.

Decomposition:
- Shared package mips_pkg holds:
  - the dmem_state_t encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2);
  - the TIMEOUT_CYCLES default;
  - the BE_ALL=4'b1111 constant.
- One natural sub-module, dmem_timeout_ctr: a saturating counter with clear, enable and expire outputs, instantiated only under DMEM_TIMEOUT_EN.

Test Plan:
- Zero-wait load: mem_read_M=1, alu_out_M=32'h0000_1006, bus_ready=1 in first REQ cycle with rdata 32'hCAFE_F00D → bus_addr=32'h0000_1004, bus_be=4'hF, ack=0 for 2 cycles, then ack=1 with read_data_M=32'hCAFE_F00D.
- Store with 3 wait states: byte_en_M=4'b0100, write_data_M=32'h5A5A_5A5A → bus_we=1, bus_be=4'b0100 held for 4 REQ cycles, ack rises the cycle after bus_ready.
- Stall hold: DONE with m_advance=0 for 5 cycles → ack and read data stable, bus_req stays 0, exactly one bus transaction.
- Flush during REQ: flush_M pulse while waiting → transaction completes, FSM goes to IDLE without DONE, ack never presents stale data.
- Error/timeout with DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus_ready held 0 → bus_req drops after 8 cycles, DONE with mem_err_M=1, read_data_M=0. Separately, bus_err=1 with bus_ready → mem_err_M=1.
- Async reset asserted in REQ → bus_req=0, ack returns to the IDLE-defined value in the same cycle.
